// File: rtl/load_store_unit.sv
// Load/store unit sitting between the datapath and the word-wide DataMemory port.
// Handles one request at a time. Loads extract and extend byte/half lanes; sub-word
// stores read the containing word, merge the new lane(s) and write the word back.
// Misaligned, out-of-range and illegal-size requests are answered with a fault and
// never reach memory.
module load_store_unit #(
   parameter int          MEM_RD_LATENCY = 1,
   parameter logic [31:0] ADDR_LIMIT     = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateT;

   localparam logic [1:0] SZ_BYTE   = 2'b00;
   localparam logic [1:0] SZ_HALF   = 2'b01;
   localparam logic [1:0] SZ_WORD   = 2'b10;
   localparam logic [1:0] SZ_BAD    = 2'b11;
   localparam logic [1:0] LAST_WAIT = 2'(MEM_RD_LATENCY);

   stateT       state;
   stateT       nextState;
   logic        accept;
   logic        reqFault;
   logic        readDone;
   logic        isWrite;
   logic [1:0]  sizeReg;
   logic        signedReg;
   logic [31:0] addrReg;
   logic [31:0] wdataReg;
   logic [1:0]  waitCount;
   logic [31:0] rdWord;
   logic [31:0] respData;
   logic        faultReg;
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] loadValue;
   logic [31:0] mergedWord;

   assign accept      = req_valid & req_ready;
   assign readDone    = (state == READ) && (waitCount == LAST_WAIT);
   assign resp_rdata  = respData;
   assign mem_address = {addrReg[31:2], 2'b00};

   // A request is rejected up front if its size is illegal, it is not naturally
   // aligned for its size, or it lies beyond the end of the memory.
   always_comb begin
      reqFault = (req_size == SZ_BAD)
               | ((req_size == SZ_HALF) & req_addr[0])
               | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
               | (req_addr >= ADDR_LIMIT);
   end

   // State register; reset abandons whatever request was in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Faults answer immediately, word stores skip the read, everything else reads
   // first and waits out the memory latency before moving on.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (reqFault) begin
                  nextState = RESP;
               end else if (req_write && (req_size == SZ_WORD)) begin
                  nextState = WRITE;
               end else begin
                  nextState = READ;
               end
            end
         end
         READ: begin
            if (readDone) begin
               nextState = isWrite ? WRITE : RESP;
            end
         end
         WRITE:   nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Request fields are captured once on accept so that later changes on the request
   // bus cannot disturb the operation; the response word is settled on the way to RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         isWrite   <= 1'b0;
         sizeReg   <= 2'b00;
         signedReg <= 1'b0;
         addrReg   <= 32'h0;
         wdataReg  <= 32'h0;
         waitCount <= 2'b00;
         rdWord    <= 32'h0;
         respData  <= 32'h0;
         faultReg  <= 1'b0;
      end else begin
         if (accept) begin
            isWrite   <= req_write;
            sizeReg   <= req_size;
            signedReg <= req_signed;
            addrReg   <= req_addr;
            wdataReg  <= req_wdata;
            waitCount <= 2'b00;
            faultReg  <= reqFault;
            if (reqFault) begin
               respData <= 32'h0;
            end
         end
         if (state == READ) begin
            waitCount <= waitCount + 2'b01;
            if (readDone) begin
               rdWord <= mem_rdata;
               if (!isWrite) begin
                  respData <= loadValue;
               end
            end
         end
         if (state == WRITE) begin
            respData <= 32'h0;
         end
      end
   end

   // Little-endian lane selection from the returned word, followed by sign or zero
   // extension; word loads pass straight through regardless of the signed flag.
   always_comb begin
      case (addrReg[1:0])
         2'b00:   laneByte = mem_rdata[7:0];
         2'b01:   laneByte = mem_rdata[15:8];
         2'b10:   laneByte = mem_rdata[23:16];
         default: laneByte = mem_rdata[31:24];
      endcase
      laneHalf = addrReg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (sizeReg)
         SZ_BYTE: loadValue = {{24{signedReg & laneByte[7]}}, laneByte};
         SZ_HALF: loadValue = {{16{signedReg & laneHalf[15]}}, laneHalf};
         default: loadValue = mem_rdata;
      endcase
   end

   // Sub-word stores overwrite only the addressed lane(s) of the word read earlier;
   // word stores take the store data as-is.
   always_comb begin
      mergedWord = rdWord;
      case (sizeReg)
         SZ_BYTE: begin
            case (addrReg[1:0])
               2'b00:   mergedWord[7:0]   = wdataReg[7:0];
               2'b01:   mergedWord[15:8]  = wdataReg[7:0];
               2'b10:   mergedWord[23:16] = wdataReg[7:0];
               default: mergedWord[31:24] = wdataReg[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addrReg[1]) begin
               mergedWord[31:16] = wdataReg[15:0];
            end else begin
               mergedWord[15:0] = wdataReg[15:0];
            end
         end
         default: mergedWord = wdataReg;
      endcase
   end

   // Handshake and memory strobes; reset masks them immediately so an abandoned store
   // never writes and an abandoned request never responds.
   always_comb begin
      req_ready  = (state == IDLE) & ~rst;
      resp_valid = (state == RESP) & ~rst;
      resp_fault = resp_valid & faultReg;
      mem_write  = (state == WRITE) & ~rst;
      mem_wdata  = (state == WRITE) ? mergedWord : 32'h0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-read DataMemory model.
module tb_load_store_unit;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:1023];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   load_store_unit #(
      .MEM_RD_LATENCY(1),
      .ADDR_LIMIT(32'h0000_1000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_size(req_size),
      .req_signed(req_signed),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_fault(resp_fault),
      .mem_write(mem_write),
      .mem_address(mem_address),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // DataMemory model: registered read, so data follows the address by one cycle.
   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_address[11:2]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_address[11:2]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Issues one request and watches up to 20 cycles after the accept edge, recording
   // the cycle offsets of the first mem_write and of resp_valid.
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic fault,
                                output int respCyc, output int wrCyc,
                                output logic [31:0] wrAddr, output logic [31:0] wrData,
                                output int wrCount);
      int waitCyc;
      rdata   = 32'h0;
      fault   = 1'b0;
      respCyc = -1;
      wrCyc   = -1;
      wrAddr  = 32'h0;
      wrData  = 32'h0;
      wrCount = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wdata;
      waitCyc = 0;
      while (!req_ready && waitCyc < 20) begin
         @(negedge clk);
         waitCyc++;
      end
      if (!req_ready) begin
         checkOutput("acceptTimeout", {31'b0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_size  = SZ_BAD;
      req_addr  = 32'hDEAD_BEEF;
      req_wdata = 32'hFFFF_FFFF;
      for (int k = 1; k <= 20 && respCyc < 0; k++) begin
         @(negedge clk);
         if (mem_write) begin
            wrCount++;
            if (wrCyc < 0) begin
               wrCyc  = k;
               wrAddr = mem_address;
               wrData = mem_wdata;
            end
         end
         if (resp_valid) begin
            respCyc = k;
            rdata   = resp_rdata;
            fault   = resp_fault;
         end
      end
   endtask

   // One request with its hand-computed outcome; expWr of -1 means no memory write.
   task automatic runVector(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] expRdata, input logic expFault,
                            input int expResp, input int expWr, input logic [31:0] expWrData);
      logic [31:0] rdata;
      logic        fault;
      int          respCyc;
      int          wrCyc;
      logic [31:0] wrAddr;
      logic [31:0] wrData;
      int          wrCount;
      applyStimulus(w, sz, sg, addr, wdata, rdata, fault, respCyc, wrCyc, wrAddr, wrData, wrCount);
      checkOutput({tag, " rdata"}, rdata, expRdata);
      checkOutput({tag, " fault"}, {31'b0, fault}, {31'b0, expFault});
      checkOutput({tag, " respCycle"}, 32'(respCyc), 32'(expResp));
      checkOutput({tag, " writeCycle"}, 32'(wrCyc), 32'(expWr));
      if (expWr >= 0) begin
         checkOutput({tag, " writeData"}, wrData, expWrData);
         checkOutput({tag, " writeAddr"}, wrAddr, {addr[31:2], 2'b00});
         checkOutput({tag, " writeCount"}, 32'(wrCount), 32'd1);
      end
   endtask

   // Stream of loads with req_valid held high throughout.
   task automatic runStream();
      logic [31:0] got [3];
      logic [31:0] want [3];
      int acc;
      int nResp;
      int viol;
      logic busy;
      logic accNow;
      want[0] = 32'h0000_000A;
      want[1] = 32'h0000_000B;
      want[2] = 32'h0000_000C;
      got[0] = 32'h0;
      got[1] = 32'h0;
      got[2] = 32'h0;
      acc = 0;
      nResp = 0;
      viol = 0;
      busy = 1'b0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = SZ_WORD;
      req_signed = 1'b0;
      req_addr   = 32'd40;
      req_wdata  = 32'h0;
      for (int k = 0; k < 60 && nResp < 3; k++) begin
         if (resp_valid) begin
            got[nResp] = resp_rdata;
            nResp++;
            busy = 1'b0;
         end else if (busy && req_ready) begin
            viol++;
         end
         accNow = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (accNow) begin
            acc++;
            busy = 1'b1;
            if (acc < 3) begin
               req_addr = 32'(40 + 4 * acc);
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("t5 accepts", 32'(acc), 32'd3);
      checkOutput("t5 responses", 32'(nResp), 32'd3);
      checkOutput("t5 readyWhileBusy", 32'(viol), 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("t5 rdata%0d", i), got[i], want[i]);
      end
   endtask

   // Reset lands while a byte store sits in WRITE.
   task automatic runResetAbort();
      int k;
      int respSeen;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = SZ_BYTE;
      req_signed = 1'b0;
      req_addr   = 32'd25;
      req_wdata  = 32'h0000_0077;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!mem_write && k < 10);
      checkOutput("t6 writeCycle", 32'(k), 32'd3);
      rst = 1'b1;
      #1;
      checkOutput("t6 memWriteInReset", {31'b0, mem_write}, 32'd0);
      checkOutput("t6 respInReset", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("t6 readyAfterReset", {31'b0, req_ready}, 32'd1);
      respSeen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid) respSeen++;
      end
      checkOutput("t6 noResponse", 32'(respSeen), 32'd0);
      checkOutput("t6 wordUnchanged", mem[6], 32'h1122_3344);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = SZ_BYTE;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("reset resp_valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("reset resp_fault", {31'b0, resp_fault}, 32'd0);
      checkOutput("reset mem_write", {31'b0, mem_write}, 32'd0);
      checkOutput("reset mem_address", mem_address, 32'h0);
      checkOutput("reset mem_wdata", mem_wdata, 32'h0);
      checkOutput("reset resp_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      #1;
      checkOutput("reset readyAfter", {31'b0, req_ready}, 32'd1);

      runVector("t1 storeWord", 1'b1, SZ_WORD, 1'b0, 32'd24, 32'd1234, 32'h0, 1'b0, 2, 1, 32'd1234);
      runVector("t1 loadWord", 1'b0, SZ_WORD, 1'b0, 32'd24, 32'h0, 32'd1234, 1'b0, 3, -1, 32'h0);

      runVector("t2 storeWord", 1'b1, SZ_WORD, 1'b0, 32'd24, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 32'h1122_3344);
      runVector("t2 storeByte", 1'b1, SZ_BYTE, 1'b0, 32'd25, 32'h0000_00AB, 32'h0, 1'b0, 4, 3, 32'h1122_AB44);
      checkOutput("t2 memWord", mem[6], 32'h1122_AB44);
      runVector("t2 loadByteS", 1'b0, SZ_BYTE, 1'b1, 32'd25, 32'h0, 32'hFFFF_FFAB, 1'b0, 3, -1, 32'h0);
      runVector("t2 loadByteU", 1'b0, SZ_BYTE, 1'b0, 32'd25, 32'h0, 32'h0000_00AB, 1'b0, 3, -1, 32'h0);
      runVector("t2 storeByteTop", 1'b1, SZ_BYTE, 1'b1, 32'd27, 32'hFFFF_FF5A, 32'h0, 1'b0, 4, 3, 32'h5A22_AB44);

      runVector("t3 storeWord", 1'b1, SZ_WORD, 1'b0, 32'd28, 32'h8001_0000, 32'h0, 1'b0, 2, 1, 32'h8001_0000);
      runVector("t3 loadHalfS", 1'b0, SZ_HALF, 1'b1, 32'd30, 32'h0, 32'hFFFF_8001, 1'b0, 3, -1, 32'h0);
      runVector("t3 loadHalfU", 1'b0, SZ_HALF, 1'b0, 32'd30, 32'h0, 32'h0000_8001, 1'b0, 3, -1, 32'h0);
      runVector("t3 storeHalfMis", 1'b1, SZ_HALF, 1'b0, 32'd31, 32'h0000_1234, 32'h0, 1'b1, 1, -1, 32'h0);
      runVector("t3 storeHalfLow", 1'b1, SZ_HALF, 1'b0, 32'd28, 32'h1234_BEEF, 32'h0, 1'b0, 4, 3, 32'h8001_BEEF);
      runVector("t3 loadWordSgn", 1'b0, SZ_WORD, 1'b1, 32'd28, 32'h0, 32'h8001_BEEF, 1'b0, 3, -1, 32'h0);

      runVector("t4 limit", 1'b0, SZ_WORD, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
      runVector("t4 badSize", 1'b0, SZ_BAD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
      runVector("t4 misWord", 1'b0, SZ_WORD, 1'b0, 32'd6, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
      runVector("t4 storeLast", 1'b1, SZ_WORD, 1'b0, 32'h0000_0FFC, 32'hCAFE_0001, 32'h0, 1'b0, 2, 1, 32'hCAFE_0001);
      runVector("t4 loadLastByte", 1'b0, SZ_BYTE, 1'b1, 32'h0000_0FFF, 32'h0, 32'hFFFF_FFCA, 1'b0, 3, -1, 32'h0);

      runVector("t5 fill0", 1'b1, SZ_WORD, 1'b0, 32'd40, 32'h0000_000A, 32'h0, 1'b0, 2, 1, 32'h0000_000A);
      runVector("t5 fill1", 1'b1, SZ_WORD, 1'b0, 32'd44, 32'h0000_000B, 32'h0, 1'b0, 2, 1, 32'h0000_000B);
      runVector("t5 fill2", 1'b1, SZ_WORD, 1'b0, 32'd48, 32'h0000_000C, 32'h0, 1'b0, 2, 1, 32'h0000_000C);
      runStream();

      runVector("t6 storeWord", 1'b1, SZ_WORD, 1'b0, 32'd24, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 32'h1122_3344);
      runResetAbort();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
